// File: rtl/seg7_value_scanner.sv
// 4-digit common-anode 7-segment scanner with frame-aligned value commit.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_value_scanner #(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic        wr_blink,
   output logic        ready,
   output logic        wr_drop,
   output logic [15:0] cur_value,
   output logic [10:0] display_out
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);

   logic [SW-1:0] scan_cnt;
   logic [BW-1:0] blink_cnt;
   logic [1:0]    idx;
   logic          blink_phase;
   logic [15:0]   pend_value;
   logic          pend_blink;
   logic          act_blink;

   logic          scan_wrap;
   logic          blink_wrap;
   logic          frame_end;
   logic          accept;
   logic [3:0]    nib;
   logic [3:0]    lz;
   logic [10:0]   disp_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      s = 7'h7F;
      unique case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign scan_wrap  = (scan_cnt == SW'(SCAN_DIV - 1));
   assign blink_wrap = (blink_cnt == BW'(BLINK_DIV - 1));
   assign frame_end  = scan_wrap && (idx == 2'd3);
   assign accept     = wr_en && ready;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   assign lz[3] = (cur_value[15:12] == 4'h0);
   assign lz[2] = lz[3] && (cur_value[11:8] == 4'h0);
   assign lz[1] = lz[2] && (cur_value[7:4] == 4'h0);
   assign lz[0] = 1'b0;
`else
   assign lz = 4'b0000;
`endif

   always_comb begin
      nib = 4'h0;
      unique case (idx)
         2'd0: nib = cur_value[3:0];
         2'd1: nib = cur_value[7:4];
         2'd2: nib = cur_value[11:8];
         2'd3: nib = cur_value[15:12];
      endcase
   end

   always_comb begin
      disp_nxt = 11'h7FF;
      if (!(act_blink && blink_phase) && !lz[idx])
         disp_nxt = {~(4'b0001 << idx), hex7(nib)};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt    <= '0;
         idx         <= 2'd0;
      end else if (scan_wrap) begin
         scan_cnt    <= '0;
         idx         <= idx + 2'd1;
      end else begin
         scan_cnt    <= scan_cnt + SW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_wrap) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BW'(1);
      end
   end

   // ready doubles as "nothing pending": accept needs it high,
   // commit needs it low, so the two can never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready      <= 1'b1;
         wr_drop    <= 1'b0;
         pend_value <= 16'h0000;
         pend_blink <= 1'b0;
         cur_value  <= 16'h0000;
         act_blink  <= 1'b0;
      end else begin
         wr_drop <= wr_en && !ready;
         if (accept) begin
            pend_value <= wr_data;
            pend_blink <= wr_blink;
            ready      <= 1'b0;
         end else if (frame_end && !ready) begin
            cur_value  <= pend_value;
            act_blink  <= pend_blink;
            ready      <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         display_out <= 11'h7FF;
      else
         display_out <= disp_nxt;
   end

endmodule

// File: tb/tb_seg7_value_scanner.sv
// Directed bench for seg7_value_scanner (SCAN_DIV=4, BLINK_DIV=64).
// Cycle n = n-th rising edge after reset release; frame boundary at n%16==0.
module tb_seg7_value_scanner;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        wr_blink;
   logic        ready;
   logic        wr_drop;
   logic [15:0] cur_value;
   logic [10:0] display_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   seg7_value_scanner #(
      .SCAN_DIV (4),
      .BLINK_DIV(64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .wr_blink   (wr_blink),
      .ready      (ready),
      .wr_drop    (wr_drop),
      .cur_value  (cur_value),
      .display_out(display_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic [15:0] wr_data;
      logic        wr_blink;
      logic [10:0] disp;
      logic        rdy;
      logic [15:0] cur;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   // drive before edge cyc+1, release after it
   task automatic write(input logic [15:0] d, input logic b);
      wr_en    = 1'b1;
      wr_data  = d;
      wr_blink = b;
      tick();
      wr_en    = 1'b0;
      wr_blink = 1'b0;
   endtask

   task automatic chk_disp(input int n, input logic [10:0] exp);
      run_to(n);
      check("display", {5'd0, display_out}, {5'd0, exp});
   endtask

   logic [10:0] d0 = 11'b1110_0000001;
   logic [10:0] d1 = 11'b1101_0000001;
   logic [10:0] d2 = 11'b1011_0000001;
   logic [10:0] d3 = 11'b0111_0000001;

   initial begin
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 16'h0;
      wr_blink = 1'b0;

      for (int i = 0; i < 16; i++) begin
         tbl[i].wr_en    = 1'b0;
         tbl[i].wr_data  = 16'h0;
         tbl[i].wr_blink = 1'b0;
         tbl[i].rdy      = 1'b1;
         tbl[i].cur      = 16'h0;
      end
      for (int i = 0; i < 4; i++)  tbl[i].disp = d0;
      for (int i = 4; i < 8; i++)  tbl[i].disp = d1;
      for (int i = 8; i < 12; i++) tbl[i].disp = d2;
      for (int i = 12; i < 16; i++) tbl[i].disp = d3;

      repeat (2) @(negedge clk);
      check("rst_disp", {5'd0, display_out}, 16'h07FF);
      check("rst_ready", {15'd0, ready}, 16'h1);
      check("rst_drop", {15'd0, wr_drop}, 16'h0);
      check("rst_cur", cur_value, 16'h0);
      rst_n = 1'b1;
      cyc   = 0;

      // idle scan after reset
      for (int i = 0; i < 16; i++) begin
         wr_en    = tbl[i].wr_en;
         wr_data  = tbl[i].wr_data;
         wr_blink = tbl[i].wr_blink;
         tick();
         check("scan_disp", {5'd0, display_out}, {5'd0, tbl[i].disp});
         check("scan_ready", {15'd0, ready}, {15'd0, tbl[i].rdy});
         check("scan_cur", cur_value, tbl[i].cur);
      end

      // mid-frame write, commit at edge 32
      write(16'h12AF, 1'b0);
      check("acc_ready", {15'd0, ready}, 16'h0);
      check("acc_cur", cur_value, 16'h0);
      run_to(31);
      check("pend_cur", cur_value, 16'h0);
      check("pend_ready", {15'd0, ready}, 16'h0);
      run_to(32);
      check("commit_cur", cur_value, 16'h12AF);
      check("commit_ready", {15'd0, ready}, 16'h1);
      chk_disp(33, 11'b1110_0111000);
      chk_disp(37, 11'b1101_0001000);
      chk_disp(41, 11'b1011_0010010);
      chk_disp(45, 11'b0111_1001111);

      // accepted write then a dropped one
      run_to(48);
      write(16'h3456, 1'b0);
      check("drop_idle", {15'd0, wr_drop}, 16'h0);
      write(16'hFFFF, 1'b0);
      check("drop_pulse", {15'd0, wr_drop}, 16'h1);
      tick();
      check("drop_end", {15'd0, wr_drop}, 16'h0);
      run_to(63);
      check("drop_old", cur_value, 16'h12AF);
      run_to(64);
      check("drop_commit", cur_value, 16'h3456);

      // write exactly on the boundary cycle (edge 80)
      run_to(79);
      write(16'h0C0D, 1'b0);
      check("bnd_ready", {15'd0, ready}, 16'h0);
      check("bnd_cur", cur_value, 16'h3456);
      run_to(95);
      check("bnd_wait", cur_value, 16'h3456);
      run_to(96);
      check("bnd_commit", cur_value, 16'h0C0D);
      check("bnd_rdy", {15'd0, ready}, 16'h1);

      // blink: phase is 1 for edges 64..127 and 192..255
      write(16'h0BEE, 1'b1);
      run_to(112);
      check("blink_cur", cur_value, 16'h0BEE);
      chk_disp(113, 11'h7FF);
      chk_disp(120, 11'h7FF);
      chk_disp(128, 11'h7FF);
      chk_disp(129, 11'b1110_0110000);
      chk_disp(133, 11'b1101_0110000);
      chk_disp(137, 11'b1011_1100000);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      chk_disp(141, 11'h7FF);
`else
      chk_disp(141, d3);
`endif
      chk_disp(193, 11'h7FF);

      // leading-zero handling for 0x0005
      write(16'h0005, 1'b0);
      run_to(208);
      check("lz_cur", cur_value, 16'h0005);
      chk_disp(209, 11'b1110_0100100);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      chk_disp(213, 11'h7FF);
      chk_disp(217, 11'h7FF);
      chk_disp(221, 11'h7FF);
`else
      chk_disp(213, d1);
      chk_disp(217, d2);
      chk_disp(221, d3);
`endif

      // reset mid-frame with a write pending
      run_to(222);
      write(16'h9999, 1'b0);
      check("pre_rst_ready", {15'd0, ready}, 16'h0);
      run_to(225);
      rst_n = 1'b0;
      #1;
      check("arst_disp", {5'd0, display_out}, 16'h07FF);
      check("arst_ready", {15'd0, ready}, 16'h1);
      check("arst_cur", cur_value, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      chk_disp(1, d0);
      run_to(16);
      check("post_rst_cur", cur_value, 16'h0);
      check("post_rst_ready", {15'd0, ready}, 16'h1);
      chk_disp(17, d0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
